// File: rtl/sc_bank_ctrl.sv
// sc_bank_ctrl: round-robin arbitrated read-modify-write controller
// for a bank of 3-bit saturating counters.
module sc_bank_ctrl #(
  parameter int NREQ    = 4,
  parameter int REQW    = 2,
  parameter int NCTR    = 6,
  parameter int IDXW    = 3,
  parameter int SAT_MAX = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      clr,
  input  logic [NREQ*IDXW-1:0] idx,
  input  logic                 tbl_clr,
  output logic [NREQ-1:0]      gnt,
  output logic                 done,
  output logic [REQW-1:0]      done_id,
  output logic [2:0]           val,
  output logic                 sat,
  output logic                 err
);

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t state, state_nx;

  logic [REQW-1:0] rr_ptr;
  logic [REQW-1:0] win_id;
  logic            win_clr;
  logic [IDXW-1:0] win_idx;
  logic [2:0]      cnt [NCTR];

  logic [REQW-1:0] scan;
  logic [REQW-1:0] pick_id;
  logic            pick_ok;
  logic [2:0]      cur;
  logic [2:0]      nxt;
  logic            bad;
  logic            wr_en;

  // lowest offset from rr_ptr wins, so scan from the far end
  always_comb begin
    scan    = '0;
    pick_ok = 1'b0;
    pick_id = rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan = rr_ptr + REQW'(k);
      if (req[scan]) begin
        pick_ok = 1'b1;
        pick_id = scan;
      end
    end
  end

  always_comb begin
    cur = 3'd0;
    for (int i = 0; i < NCTR; i++) begin
      if (win_idx == IDXW'(i)) cur = cnt[i];
    end
  end

  // out-of-range index or a corrupted stored value blocks the write
  assign bad = (int'(win_idx) >= NCTR) || (int'(cur) > SAT_MAX);

  always_comb begin
    nxt = 3'd0;
    if (!win_clr) begin
      nxt = (int'(cur) >= SAT_MAX) ? 3'(SAT_MAX) : cur + 3'd1;
    end
  end

  assign wr_en = (state == UPDATE) && !bad && !tbl_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (pick_ok) state_nx = UPDATE;
      UPDATE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCTR; i++) cnt[i] <= 3'd0;
    end else begin
      for (int i = 0; i < NCTR; i++) begin
        if (tbl_clr) begin
          cnt[i] <= 3'd0;
        end else if (wr_en && win_idx == IDXW'(i)) begin
          cnt[i] <= nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr  <= '0;
      win_id  <= '0;
      win_clr <= 1'b0;
      win_idx <= '0;
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      val     <= 3'd0;
      sat     <= 1'b0;
      err     <= 1'b0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_ok) begin
            win_id  <= pick_id;
            win_clr <= clr[pick_id];
            win_idx <= idx[pick_id*IDXW +: IDXW];
            gnt     <= NREQ'(1) << pick_id;
          end
        end
        UPDATE: begin
          done    <= 1'b1;
          done_id <= win_id;
          rr_ptr  <= win_id + 1'b1;
          if (tbl_clr) begin
            val <= 3'd0;
            sat <= 1'b0;
          end else if (bad) begin
            val <= 3'd0;
            sat <= 1'b0;
            err <= 1'b1;
          end else begin
            val <= nxt;
            sat <= (int'(nxt) == SAT_MAX);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
